spi_ram_param: RTL and testbench
================================

Name: spi_ram_param

Overview:
Parametrised single-port synchronous RAM behind the SPI slave command interface. It decodes command words {cmd[1:0], payload}, keeps separate write/read address pointers with optional auto-increment, and returns read data with a tx_valid strobe. Sits between the SPI slave serial-to-parallel stage (rx side) and its parallel-to-serial return path (tx side). It supersedes the fixed 8-bit/256-deep RAM with configurable width/depth, pointer auto-increment for burst transfers, and out-of-range address detection.

Parameters:
DATA_W, 8, data/payload width in bits (>= ADDR_W)
ADDR_W, 8, address pointer width
MEM_DEPTH, 256, number of words; 1 <= MEM_DEPTH <= 2**ADDR_W
AUTO_INC, 1, 1 = pointer increments after each write/read access; 0 = pointers static

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
din  input  DATA_W+2  command word: din[DATA_W+1:DATA_W]=cmd, din[DATA_W-1:0]=payload
rx_valid  input  1  din valid this cycle; one command consumed per cycle when high
dout  output  DATA_W  read data
tx_valid  output  1  one-cycle strobe, dout valid
addr_err  output  1  one-cycle strobe, rejected out-of-range address load

Behaviour:
- Reset (async assert, sync release): dout=0, tx_valid=0, addr_err=0, wr_ptr=0, rd_ptr=0, rd_pend=0. Memory contents are not cleared. Reset mid-burst abandons a pending read; no tx_valid after reset.
- Commands decoded only when rx_valid=1; rx_valid=0 is a no-op except the output stage below.
- cmd 00 (WR_ADDR): payload[ADDR_W-1:0] < MEM_DEPTH -> wr_ptr loaded next edge; else wr_ptr unchanged and addr_err=1 for one cycle. Payload bits above ADDR_W ignored.
- cmd 01 (WR_DATA): mem[wr_ptr] <= payload; if AUTO_INC, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- cmd 10 (RD_ADDR): same rules as WR_ADDR but for rd_ptr.
- cmd 11 (RD_DATA): captures mem[rd_ptr] at edge N; rd_pend=1; edge N+1 drives dout and tx_valid=1 (latency 1 cycle after acceptance). If AUTO_INC, rd_ptr advances at edge N with the same wrap rule.
- tx_valid is high exactly one cycle per RD_DATA; low otherwise. dout holds its last value while tx_valid=0.
- Back-to-back RD_DATA on consecutive cycles fully pipelined: tx_valid stays high for consecutive cycles with successive words.
- Read-after-write: WR_DATA to address A at cycle N, RD_DATA of A at N+1 returns the new data (write commits before read capture).
- Only one command per cycle, so no same-cycle read/write conflict exists.
- Pointers wrap to 0 at MEM_DEPTH-1 even when MEM_DEPTH < 2**ADDR_W. addr_err never affects data or tx_valid.
- Pipeline structure: stage 1 = decode/memory access, stage 2 = output register.

Test Plan:
- Reset then RD_ADDR 0x00, RD_DATA -> tx_valid=0 during reset; after command, one cycle later tx_valid=1 for exactly one cycle, dout=mem[0].
- WR_ADDR 0x10, WR_DATA 0xA5, 0x5A, 0x3C (AUTO_INC=1); RD_ADDR 0x10; 3x RD_DATA back-to-back -> tx_valid high 3 consecutive cycles, dout=0xA5, 0x5A, 0x3C.
- MEM_DEPTH=200: WR_ADDR 0xC7, WR_DATA 0x11, WR_DATA 0x22 -> mem[199]=0x11, mem[0]=0x22 (wrap). WR_ADDR 0xC8 -> addr_err one-cycle pulse, wr_ptr stays at 1.
- WR_ADDR 0x05, WR_DATA 0x77, then RD_ADDR 0x05, RD_DATA on the immediately following cycles -> dout=0x77.
- AUTO_INC=0: RD_ADDR 0x05, RD_DATA x2 -> both return mem[5]. Assert rst the cycle after RD_DATA -> tx_valid=0, dout=0, no late strobe after release.
- rx_valid=0 with random din for 20 cycles -> no memory/pointer change, tx_valid=0, addr_err=0.

Source files
------------

// File: rtl/spi_ram_param_if.sv
// ---------------------------------------------------------------------------
// spi_ram_param_if
// Command/response bundle between the SPI slave shift stages and the RAM.
//   din      : command word {cmd[1:0], payload[DATA_W-1:0]} from the rx side
//   rx_valid : din valid this cycle
//   dout     : read data returned to the tx side
//   tx_valid : one-cycle strobe, dout valid
//   addr_err : one-cycle strobe, an address load was rejected
// master = SPI slave shift logic (drives commands), slave = RAM block.
// ---------------------------------------------------------------------------
interface spi_ram_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              addr_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  addr_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output addr_err
    );
endinterface

// File: rtl/spi_ram_param.sv
// ---------------------------------------------------------------------------
// spi_ram_param
// Parametrised single-port RAM behind the SPI slave command interface.
// Decodes {cmd, payload} words, keeps independent write/read pointers with
// optional auto-increment (wrapping at MEM_DEPTH-1) and returns read data one
// cycle after the RD_DATA command with a tx_valid strobe.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (memory contents are kept)
//   bus : slave side of spi_ram_param_if (din/rx_valid in, dout/tx_valid/
//         addr_err out)
// Stage 1 decodes and accesses memory, stage 2 is the output register.
// ---------------------------------------------------------------------------
module spi_ram_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_param_if.slave bus
);
    // Memory index only needs enough bits to span MEM_DEPTH.
    localparam int                IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              tx_valid_q, tx_valid_d;
    logic              addr_err_q, addr_err_d;

    cmd_e              cmd_s;
    logic [DATA_W-1:0] payload_s;
    logic [ADDR_W-1:0] addr_s;
    logic              addr_ok_s;
    logic              mem_we_s;

    // Pointer advance with wrap at the last implemented word (not at 2**ADDR_W).
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
        logic [ADDR_W-1:0] nxt;
        if (AUTO_INC == 0) begin
            nxt = ptr;
        end else if (ptr == LAST_PTR) begin
            nxt = {ADDR_W{1'b0}};
        end else begin
            nxt = ptr + ADDR_W'(1);
        end
        return nxt;
    endfunction

    assign cmd_s     = cmd_e'(bus.din[DATA_W+1:DATA_W]);
    assign payload_s = bus.din[DATA_W-1:0];
    assign addr_s    = payload_s[ADDR_W-1:0];
    assign addr_ok_s = ({1'b0, addr_s} < DEPTH_EXT);

    // Command decode, pointer updates, read capture and output stage next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_pend_d  = 1'b0;
        addr_err_d = 1'b0;
        mem_we_s   = 1'b0;
        tx_valid_d = rd_pend_q;
        // dout only changes when a captured read is presented.
        if (rd_pend_q) begin
            dout_d = rd_data_q;
        end else begin
            dout_d = dout_q;
        end

        if (bus.rx_valid) begin
            case (cmd_s)
                CMD_WR_ADDR: begin
                    if (addr_ok_s) begin
                        wr_ptr_d = addr_s;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = next_ptr(wr_ptr_q);
                end
                CMD_RD_ADDR: begin
                    if (addr_ok_s) begin
                        rd_ptr_d = addr_s;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    // A write from the previous cycle is already in mem here.
                    rd_data_d = mem[rd_ptr_q[IDX_W-1:0]];
                    rd_pend_d = 1'b1;
                    rd_ptr_d  = next_ptr(rd_ptr_q);
                end
                default: begin
                    addr_err_d = 1'b0;
                end
            endcase
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= payload_s;
        end
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            rd_data_q  <= {DATA_W{1'b0}};
            rd_pend_q  <= 1'b0;
            dout_q     <= {DATA_W{1'b0}};
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_param.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_param
// Two instances receive identical command streams:
//   dut_a : MEM_DEPTH=200, AUTO_INC=1 (wrap below 2**ADDR_W, range errors)
//   dut_b : MEM_DEPTH=256, AUTO_INC=0 (static pointers)
// A behavioural model (arrays + a queue of due read results) predicts
// tx_valid, dout and addr_err for both after every clock edge.
// ---------------------------------------------------------------------------
module tb_spi_ram_param;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_ram_param_if #(.DATA_W(8)) ifa ();
    spi_ram_param_if #(.DATA_W(8)) ifb ();

    spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int         depth [2] = '{200, 256};
    bit         inc   [2] = '{1'b1, 1'b0};
    logic [7:0] mm    [2][256];
    int         wp    [2];
    int         rp    [2];
    logic [7:0] ldout [2];
    bit         etx   [2];
    bit         eerr  [2];
    int         cyc = 0;

    typedef struct {
        int         due;
        logic [7:0] d0;
        logic [7:0] d1;
    } rd_t;
    rd_t rq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        for (int k = 0; k < 2; k++) begin
            wp[k] = 0; rp[k] = 0; ldout[k] = 8'h00; etx[k] = 1'b0; eerr[k] = 1'b0;
        end
    endtask

    // What the design must show after the clock edge that samples this command.
    task automatic model_edge(bit rxv, logic [1:0] cmd, logic [7:0] pay);
        rd_t        r;
        logic [7:0] rdv [2];
        cyc++;
        etx[0] = 1'b0; etx[1] = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            etx[0] = 1'b1; etx[1] = 1'b1;
            ldout[0] = r.d0; ldout[1] = r.d1;
        end
        for (int k = 0; k < 2; k++) begin
            eerr[k] = 1'b0;
            rdv[k]  = 8'h00;
            if (rxv) begin
                case (cmd)
                    2'b00: if (pay < depth[k]) wp[k] = pay; else eerr[k] = 1'b1;
                    2'b01: begin
                        mm[k][wp[k]] = pay;
                        if (inc[k]) wp[k] = (wp[k] + 1) % depth[k];
                    end
                    2'b10: if (pay < depth[k]) rp[k] = pay; else eerr[k] = 1'b1;
                    default: begin
                        rdv[k] = mm[k][rp[k]];
                        if (inc[k]) rp[k] = (rp[k] + 1) % depth[k];
                    end
                endcase
            end
        end
        if (rxv && cmd == 2'b11) begin
            r.due = cyc + 1; r.d0 = rdv[0]; r.d1 = rdv[1];
            rq.push_back(r);
        end
    endtask

    task automatic check_all();
        chk("a_tx_valid", ifa.tx_valid, etx[0]);
        chk("a_addr_err", ifa.addr_err, eerr[0]);
        chk("a_dout",     ifa.dout,     ldout[0]);
        chk("b_tx_valid", ifb.tx_valid, etx[1]);
        chk("b_addr_err", ifb.addr_err, eerr[1]);
        chk("b_dout",     ifb.dout,     ldout[1]);
    endtask

    // Drive at the falling edge, clock once, check at the next falling edge.
    task automatic step(bit rxv, logic [1:0] cmd, logic [7:0] pay);
        ifa.rx_valid = rxv; ifa.din = {cmd, pay};
        ifb.rx_valid = rxv; ifb.din = {cmd, pay};
        @(posedge clk);
        model_edge(rxv, cmd, pay);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 8'h00);
    endtask

    // Called at a falling edge: async assert, hold one edge, release.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    // ---------------- directed table (expectations for dut_a) ----------------
    typedef struct {
        bit         rxv;
        logic [1:0] cmd;
        logic [7:0] pay;
        bit         tx;
        bit         err;
        bit         cd;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl [22];

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 2'b01, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 2'b10, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[7]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
        tbl[8]  = '{1'b0, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C};
        tbl[9]  = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[10] = '{1'b1, 2'b00, 8'hC7, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 2'b00, 8'hC8, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 2'b00, 8'hC8, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b1, 2'b01, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{1'b1, 2'b10, 8'hC7, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[17] = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[18] = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[19] = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
        tbl[20] = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
        tbl[21] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};

        ifa.rx_valid = 1'b0; ifa.din = 10'h000;
        ifb.rx_valid = 1'b0; ifb.din = 10'h000;
        model_reset();

        @(negedge clk);
        do_reset();

        // Give every word a known value so all reads are predictable.
        for (int a = 0; a < 256; a++) begin
            step(1'b1, 2'b00, 8'(a));
            step(1'b1, 2'b01, 8'($urandom_range(255)));
        end
        idle();

        // Fresh reset, then first read of word 0.
        do_reset();
        step(1'b1, 2'b10, 8'h00);
        step(1'b1, 2'b11, 8'h00);
        chk("first_rd_no_early_tx", ifa.tx_valid, 1'b0);
        idle();
        chk("first_rd_tx",   ifa.tx_valid, 1'b1);
        chk("first_rd_dout", ifa.dout,     mm[0][0]);
        idle();
        chk("first_rd_tx_drop", ifa.tx_valid, 1'b0);

        // Burst, back-to-back reads and pointer wrap at MEM_DEPTH-1 (dut_a).
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rxv, tbl[i].cmd, tbl[i].pay);
            chk("tbl_tx",  ifa.tx_valid, tbl[i].tx);
            chk("tbl_err", ifa.addr_err, tbl[i].err);
            if (tbl[i].cd) chk("tbl_dout", ifa.dout, tbl[i].dout);
        end

        // Read immediately after write of the same address.
        step(1'b1, 2'b10, 8'h05);
        step(1'b1, 2'b00, 8'h05);
        step(1'b1, 2'b01, 8'h77);
        step(1'b1, 2'b11, 8'h00);
        idle();
        chk("raw_a_dout", ifa.dout, 8'h77);
        chk("raw_b_dout", ifb.dout, 8'h77);

        // Static pointers: two reads both return word 5 (dut_b).
        step(1'b1, 2'b10, 8'h05);
        step(1'b1, 2'b11, 8'h00);
        step(1'b1, 2'b11, 8'h00);
        chk("noinc_rd1_tx",   ifb.tx_valid, 1'b1);
        chk("noinc_rd1_dout", ifb.dout,     8'h77);
        idle();
        chk("noinc_rd2_tx",   ifb.tx_valid, 1'b1);
        chk("noinc_rd2_dout", ifb.dout,     8'h77);
        idle();

        // Reset while a read is in flight: the strobe must never appear.
        step(1'b1, 2'b11, 8'h00);
        do_reset();
        chk("rst_abandon_dout", ifb.dout, 8'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rst_no_late_tx", ifb.tx_valid, 1'b0);
        end

        // rx_valid low with random din must be a no-op.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'($urandom_range(3)), 8'($urandom_range(255)));
        end

        // Random command stream against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), 2'($urandom_range(3)), 8'($urandom_range(255)));
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
